// File: rtl/reg_scoreboard_if.sv
// Issue / completion / status bundle between decode and the register scoreboard.
//   master : decode-side driver (issue offer, mem/wb completions, flush);
//            observes stall and tracking status
//   slave  : the scoreboard
// Index fields are $clog2(NREG) bits wide (5 bits for the default 32 registers).
interface reg_scoreboard_if #(
    parameter int NREG = 32
);
    localparam int IDX_W = $clog2(NREG);

    logic             iss_valid;
    logic             iss_accept;
    logic [IDX_W-1:0] iss_rd;
    logic             iss_wen;
    logic             iss_is_load;
    logic [IDX_W-1:0] iss_rs1;
    logic             iss_rs1_used;
    logic [IDX_W-1:0] iss_rs2;
    logic             iss_rs2_used;
    logic             mem_done;
    logic [IDX_W-1:0] mem_rd;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_rd;
    logic             wb_wen;
    logic             sb_clear;
    logic             iss_stall;
    logic [NREG-1:0]  busy_mask;
    logic [7:0]       inflight;
    logic             err_underflow;

    modport master (
        output iss_valid, iss_accept, iss_rd, iss_wen, iss_is_load,
               iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used,
               mem_done, mem_rd, wb_valid, wb_rd, wb_wen, sb_clear,
        input  iss_stall, busy_mask, inflight, err_underflow
    );

    modport slave (
        input  iss_valid, iss_accept, iss_rd, iss_wen, iss_is_load,
               iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used,
               mem_done, mem_rd, wb_valid, wb_rd, wb_wen, sb_clear,
        output iss_stall, busy_mask, inflight, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register issue scoreboard.
// Counts in-flight writes (wr_cnt) and outstanding loads (ld_cnt) per
// architectural register, stalls decode on load-use and write-counter
// saturation, and releases entries on mem_done / writeback.
//   reg_sb_entry   : one register's pair of counters with net-delta update
//   reg_scoreboard : event decode, stall logic, registered status
// Ports (reg_scoreboard):
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   sb   reg_scoreboard_if.slave (issue offer/handshake, mem_done, writeback,
//        sb_clear in; iss_stall (comb), busy_mask, inflight, err_underflow out)

module reg_sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_w,
    input  logic             dec_w,
    input  logic             inc_l,
    input  logic             dec_l,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] wr_nxt,
    output logic             uf
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] ld_nxt;
    logic             uf_w, uf_l;

    // An increment and a decrement in the same cycle cancel before any
    // saturation or underflow check is made.
    always_comb begin
        wr_nxt = wr_cnt;
        ld_nxt = ld_cnt;
        uf_w   = 1'b0;
        uf_l   = 1'b0;
        if (inc_w && !dec_w) begin
            if (wr_cnt != MAX) wr_nxt = wr_cnt + 1'b1;
        end else if (dec_w && !inc_w) begin
            if (wr_cnt == '0) uf_w = 1'b1;
            else              wr_nxt = wr_cnt - 1'b1;
        end
        if (inc_l && !dec_l) begin
            if (ld_cnt != MAX) ld_nxt = ld_cnt + 1'b1;
        end else if (dec_l && !inc_l) begin
            if (ld_cnt == '0) uf_l = 1'b1;
            else              ld_nxt = ld_cnt - 1'b1;
        end
        // Flush overrides every same-cycle event, including error reporting.
        if (clr) begin
            wr_nxt = '0;
            ld_nxt = '0;
            uf_w   = 1'b0;
            uf_l   = 1'b0;
        end
    end

    assign uf = uf_w | uf_l;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
            ld_cnt <= '0;
        end else begin
            wr_cnt <= wr_nxt;
            ld_cnt <= ld_nxt;
        end
    end
endmodule

module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);
    localparam int IDX_W = $clog2(NREG);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] wr_cnt, ld_cnt, wr_nxt;
    logic [NREG-1:0]            inc_w, dec_w, inc_l, dec_l, uf_vec, busy_nxt;
    logic [7:0]                 infl_nxt;
    logic                       rs1_hit, rs2_hit, rd_sat, stall;
    logic                       issue_ok, proto_err;

    // Stall looks only at registered counters: no same-cycle bypass, so a
    // load issued at T blocks its consumer from T+1.
    assign rs1_hit = sb.iss_rs1_used && (sb.iss_rs1 != '0) && (ld_cnt[sb.iss_rs1] != '0);
    assign rs2_hit = sb.iss_rs2_used && (sb.iss_rs2 != '0) && (ld_cnt[sb.iss_rs2] != '0);
    assign rd_sat  = sb.iss_wen && (sb.iss_rd != '0) && (wr_cnt[sb.iss_rd] == MAX);
    assign stall   = sb.iss_valid && (rs1_hit || rs2_hit || rd_sat);

    assign sb.iss_stall = stall;

    // A handshake that fires against a stall is dropped and flagged.
    assign issue_ok  = sb.iss_accept && !stall;
    assign proto_err = sb.iss_accept && stall;

    always_comb begin
        inc_w = '0;
        inc_l = '0;
        dec_w = '0;
        dec_l = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_w[r] = issue_ok && sb.iss_wen && (sb.iss_rd == IDX_W'(r));
            inc_l[r] = inc_w[r] && sb.iss_is_load;
            dec_l[r] = sb.mem_done && (sb.mem_rd == IDX_W'(r));
            dec_w[r] = sb.wb_valid && sb.wb_wen && (sb.wb_rd == IDX_W'(r));
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : gen_reg
        if (r == 0) begin : gen_x0
            // x0 never holds a pending write.
            assign wr_cnt[r] = '0;
            assign ld_cnt[r] = '0;
            assign wr_nxt[r] = '0;
            assign uf_vec[r] = 1'b0;
        end else begin : gen_ent
            reg_sb_entry #(.CNT_W(CNT_W)) u_ent (
                .clk    (clk),
                .rst    (rst),
                .clr    (sb.sb_clear),
                .inc_w  (inc_w[r]),
                .dec_w  (dec_w[r]),
                .inc_l  (inc_l[r]),
                .dec_l  (dec_l[r]),
                .wr_cnt (wr_cnt[r]),
                .ld_cnt (ld_cnt[r]),
                .wr_nxt (wr_nxt[r]),
                .uf     (uf_vec[r])
            );
        end
    end

    // Status is computed from next-state counts so the registered outputs
    // line up with the counters after the same edge.
    always_comb begin
        infl_nxt = '0;
        busy_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            infl_nxt    = infl_nxt + 8'(wr_nxt[r]);
            busy_nxt[r] = |wr_nxt[r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb.busy_mask     <= '0;
            sb.inflight      <= '0;
            sb.err_underflow <= 1'b0;
        end else begin
            sb.busy_mask <= busy_nxt;
            sb.inflight  <= infl_nxt;
            if (!sb.sb_clear && (proto_err || (|uf_vec)))
                sb.err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-cycle vector table (inputs plus
// expected stall and post-edge status) followed by hand sequences for the
// asynchronous reset and a handshake against a stall.
module tb_reg_scoreboard;
    logic clk;
    logic rst;

    reg_scoreboard_if #(.NREG(32)) sbi ();

    reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, acc;
        logic [4:0]  rd;
        logic        wen, ld;
        logic [4:0]  rs1;
        logic        rs1u;
        logic [4:0]  rs2;
        logic        rs2u;
        logic        md;
        logic [4:0]  mrd;
        logic        wb;
        logic [4:0]  wbrd;
        logic        clr;
        logic        e_stall;
        logic [31:0] e_busy;
        logic [7:0]  e_infl;
        logic        e_err;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic valid, acc, input logic [4:0] rd, input logic wen, ld,
        input logic [4:0] rs1, input logic rs1u, input logic [4:0] rs2, input logic rs2u,
        input logic md, input logic [4:0] mrd, input logic wb, input logic [4:0] wbrd,
        input logic clr, input logic e_stall, input logic [31:0] e_busy,
        input logic [7:0] e_infl, input logic e_err);
        vec_t v;
        v.valid = valid; v.acc = acc; v.rd = rd; v.wen = wen; v.ld = ld;
        v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
        v.md = md; v.mrd = mrd; v.wb = wb; v.wbrd = wbrd; v.clr = clr;
        v.e_stall = e_stall; v.e_busy = e_busy; v.e_infl = e_infl; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sbi.iss_valid    = v.valid;
        sbi.iss_accept   = v.acc;
        sbi.iss_rd       = v.rd;
        sbi.iss_wen      = v.wen;
        sbi.iss_is_load  = v.ld;
        sbi.iss_rs1      = v.rs1;
        sbi.iss_rs1_used = v.rs1u;
        sbi.iss_rs2      = v.rs2;
        sbi.iss_rs2_used = v.rs2u;
        sbi.mem_done     = v.md;
        sbi.mem_rd       = v.mrd;
        sbi.wb_valid     = v.wb;
        sbi.wb_rd        = v.wbrd;
        sbi.wb_wen       = v.wb;
        sbi.sb_clear     = v.clr;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0, 0,32'h0,8'd0,0));
    endtask

    // Drive one vector, check the combinational stall, clock it, then check
    // the registered status.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #1;
        chk("iss_stall", idx, 32'(sbi.iss_stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk("busy_mask", idx, sbi.busy_mask, v.e_busy);
        chk("inflight", idx, 32'(sbi.inflight), 32'(v.e_infl));
        chk("err_underflow", idx, 32'(sbi.err_underflow), 32'(v.e_err));
    endtask

    localparam logic [31:0] B3 = 32'h0000_0008;
    localparam logic [31:0] B5 = 32'h0000_0020;
    localparam logic [31:0] B6 = 32'h0000_0040;
    localparam logic [31:0] B7 = 32'h0000_0080;
    localparam logic [31:0] B10 = 32'h0000_0400;

    initial begin
        // columns: valid acc rd wen ld | rs1 rs1u rs2 rs2u | md mrd | wb wbrd | clr | stall busy infl err
        vq.push_back(mk(0,0, 0,0,0,  0,0, 0,0, 0,0,  0,0,  0, 0, 32'h0,   8'd0, 0)); // 0 idle
        // load-use on x5
        vq.push_back(mk(1,1, 5,1,1,  0,0, 0,0, 0,0,  0,0,  0, 0, B5,      8'd1, 0)); // 1 load rd=5
        vq.push_back(mk(1,0, 6,1,0,  5,1, 0,0, 0,0,  0,0,  0, 1, B5,      8'd1, 0)); // 2 consumer stalls
        vq.push_back(mk(1,0, 6,1,0,  5,1, 0,0, 1,5,  0,0,  0, 1, B5,      8'd1, 0)); // 3 mem_done, still stalled
        vq.push_back(mk(1,1, 6,1,0,  5,1, 0,0, 0,0,  0,0,  0, 0, B5|B6,   8'd2, 0)); // 4 stall released
        vq.push_back(mk(0,0, 0,0,0,  0,0, 0,0, 0,0,  1,5,  0, 0, B6,      8'd1, 0)); // 5 wb x5
        vq.push_back(mk(0,0, 0,0,0,  0,0, 0,0, 0,0,  1,6,  0, 0, 32'h0,   8'd0, 0)); // 6 wb x6
        // saturation on x7
        vq.push_back(mk(1,1, 7,1,0,  0,0, 0,0, 0,0,  0,0,  0, 0, B7,      8'd1, 0)); // 7
        vq.push_back(mk(1,1, 7,1,0,  0,0, 0,0, 0,0,  0,0,  0, 0, B7,      8'd2, 0)); // 8
        vq.push_back(mk(1,1, 7,1,0,  0,0, 0,0, 0,0,  0,0,  0, 0, B7,      8'd3, 0)); // 9
        vq.push_back(mk(1,0, 7,1,0,  0,0, 0,0, 0,0,  0,0,  0, 1, B7,      8'd3, 0)); // 10 saturated
        vq.push_back(mk(1,0, 7,1,0,  0,0, 0,0, 0,0,  1,7,  0, 1, B7,      8'd2, 0)); // 11 wb, drops next cycle
        vq.push_back(mk(1,1, 7,1,0,  0,0, 0,0, 0,0,  0,0,  0, 0, B7,      8'd3, 0)); // 12 issue allowed again
        // flush with a concurrent issue
        vq.push_back(mk(1,1, 4,1,0,  0,0, 0,0, 0,0,  0,0,  1, 0, 32'h0,   8'd0, 0)); // 13
        // simultaneous issue + wb on x3
        vq.push_back(mk(1,1, 3,1,0,  0,0, 0,0, 0,0,  0,0,  0, 0, B3,      8'd1, 0)); // 14
        vq.push_back(mk(1,1, 3,1,0,  0,0, 0,0, 0,0,  1,3,  0, 0, B3,      8'd1, 0)); // 15 net zero
        // mem_done + new load on x10
        vq.push_back(mk(1,1,10,1,1,  0,0, 0,0, 0,0,  0,0,  0, 0, B3|B10,  8'd2, 0)); // 16
        vq.push_back(mk(1,1,10,1,1,  0,0, 0,0, 1,10, 0,0,  0, 0, B3|B10,  8'd3, 0)); // 17 ld_cnt stays 1
        vq.push_back(mk(1,0, 0,0,0,  0,0,10,1, 0,0,  0,0,  0, 1, B3|B10,  8'd3, 0)); // 18 rs2 load-use
        vq.push_back(mk(0,0, 0,0,0, 10,1,10,1, 0,0,  0,0,  0, 0, B3|B10,  8'd3, 0)); // 19 no stall without valid
        // x0 and underflow
        vq.push_back(mk(1,1, 0,1,1,  0,1, 0,0, 0,0,  0,0,  0, 0, B3|B10,  8'd3, 0)); // 20 issue x0 ignored
        vq.push_back(mk(0,0, 0,0,0,  0,0, 0,0, 1,0,  1,0,  0, 0, B3|B10,  8'd3, 0)); // 21 release x0 ignored
        vq.push_back(mk(0,0, 0,0,0,  0,0, 0,0, 0,0,  1,9,  0, 0, B3|B10,  8'd3, 1)); // 22 wb x9 at zero
        vq.push_back(mk(0,0, 0,0,0,  0,0, 0,0, 0,0,  0,0,  0, 0, B3|B10,  8'd3, 1)); // 23 sticky

        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy_mask", -1, sbi.busy_mask, 32'h0);
        chk("reset inflight", -1, 32'(sbi.inflight), 32'h0);
        chk("reset err", -1, 32'(sbi.err_underflow), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Asynchronous reset mid-run: counters nonzero, no clock edge needed.
        idle();
        rst = 1'b0;
        #1;
        chk("async busy_mask", 100, sbi.busy_mask, 32'h0);
        chk("async inflight", 100, 32'(sbi.inflight), 32'h0);
        chk("async err", 100, 32'(sbi.err_underflow), 32'h0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset stall", 101, 32'(sbi.iss_stall), 32'h0);

        // Handshake against a stall is dropped and flagged.
        apply(mk(1,1, 5,1,1, 0,0, 0,0, 0,0, 0,0, 0, 0, B5, 8'd1, 0), 102);
        apply(mk(1,1, 8,1,0, 5,1, 0,0, 0,0, 0,0, 0, 1, B5, 8'd1, 1), 103);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
